// File: rtl/alu_core_if.sv
// Operand/command bus feeding alu_core: clock enable, mode, command,
// per-operand valid strobes, operands and carry-in.
interface alu_core_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
);
    logic                 ce;
    logic                 mode;
    logic [CMD_WIDTH-1:0] cmd;
    logic [1:0]           inpValid;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 cin;

    modport master (output ce, mode, cmd, inpValid, opa, opb, cin);
    modport slave  (input  ce, mode, cmd, inpValid, opa, opb, cin);
endinterface

// File: rtl/alu_core.sv
// Multi-cycle ALU: arithmetic and logical commands, operands may arrive on
// separate cycles (bounded wait), multiplies take an extra stage, and the
// outputs float until the first result after reset.
module alu_core #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    alu_core_if.slave      aluBus,
    output wire [WIDTH:0]  res_o,
    output wire            err_o,
    output wire            oflow_o,
    output wire            cout_o,
    output wire            g_o,
    output wire            l_o,
    output wire            e_o
);
    localparam int RW    = WIDTH + 1;
    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CMD_WIDTH-1:0] A_ADD    = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] A_SUB    = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] A_ADD_IN = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] A_SUB_IN = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] A_INC_A  = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] A_DEC_A  = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] A_INC_B  = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] A_DEC_B  = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] A_CMP    = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] A_MUL_IN = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] A_MUL_S  = CMD_WIDTH'(10);

    localparam logic [CMD_WIDTH-1:0] L_AND    = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] L_NAND   = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] L_OR     = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] L_NOR    = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] L_XOR    = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] L_XNOR   = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] L_NOT_A  = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] L_NOT_B  = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] L_SHR1_A = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] L_SHL1_A = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] L_SHR1_B = CMD_WIDTH'(10);
    localparam logic [CMD_WIDTH-1:0] L_SHL1_B = CMD_WIDTH'(11);
    localparam logic [CMD_WIDTH-1:0] L_ROL    = CMD_WIDTH'(12);
    localparam logic [CMD_WIDTH-1:0] L_ROR    = CMD_WIDTH'(13);

    typedef enum logic [1:0] {IDLE, WAIT_OP, MUL_STAGE} state_t;

    typedef struct packed {
        logic [WIDTH:0] res;
        logic           err;
        logic           oflow;
        logic           cout;
        logic           g;
        logic           l;
        logic           e;
    } outs_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     opa_q, opb_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 mode_q, cin_q, waitB_q, outEn_q;
    outs_t                outs_q, outs_d, errOut;

    logic [WIDTH-1:0]     selA, selB, lres;
    logic [CMD_WIDTH-1:0] selCmd;
    logic                 selMode, selCin;
    logic [RW-1:0]        extA, extB;
    logic                 cmdValid, isMul, needA, needB, logErr, rotBad;
    logic [31:0]          rotAmt;
    logic                 covered, arrival;

    // Pick operands/command: live in IDLE, latched in MUL_STAGE, merged while waiting
    always_comb begin
        selA    = aluBus.opa;
        selB    = aluBus.opb;
        selCmd  = aluBus.cmd;
        selMode = aluBus.mode;
        selCin  = aluBus.cin;
        if (state_q != IDLE) begin
            selA    = (state_q == WAIT_OP && aluBus.inpValid[0]) ? aluBus.opa : opa_q;
            selB    = (state_q == WAIT_OP && aluBus.inpValid[1]) ? aluBus.opb : opb_q;
            selCmd  = cmd_q;
            selMode = mode_q;
            selCin  = cin_q;
        end
        extA = {1'b0, selA};
        extB = {1'b0, selB};
    end

    // Error result shape: RES cleared, only ERR set
    always_comb begin
        errOut     = '0;
        errOut.err = 1'b1;
    end

    // Datapath: result, flags and operand requirements for the selected command
    always_comb begin
        outs_d   = '0;
        lres     = '0;
        cmdValid = 1'b1;
        isMul    = 1'b0;
        needA    = 1'b1;
        needB    = 1'b1;
        logErr   = 1'b0;
        rotAmt   = 32'(selB[SHW-1:0]);
        rotBad   = (selB >> SHW) != '0;
        if (selMode) begin
            case (selCmd)
                A_ADD: begin
                    outs_d.res  = extA + extB;
                    outs_d.cout = outs_d.res[WIDTH];
                end
                A_SUB: begin
                    outs_d.res   = extA - extB;
                    outs_d.oflow = selA < selB;
                end
                A_ADD_IN: begin
                    outs_d.res  = extA + extB + RW'(selCin);
                    outs_d.cout = outs_d.res[WIDTH];
                end
                A_SUB_IN: begin
                    outs_d.res   = extA - extB - RW'(selCin);
                    outs_d.oflow = extA < (extB + RW'(selCin));
                end
                A_INC_A: begin
                    needB       = 1'b0;
                    outs_d.res  = extA + RW'(1);
                    outs_d.cout = outs_d.res[WIDTH];
                end
                A_DEC_A: begin
                    needB        = 1'b0;
                    outs_d.res   = extA - RW'(1);
                    outs_d.oflow = selA == '0;
                end
                A_INC_B: begin
                    needA       = 1'b0;
                    outs_d.res  = extB + RW'(1);
                    outs_d.cout = outs_d.res[WIDTH];
                end
                A_DEC_B: begin
                    needA        = 1'b0;
                    outs_d.res   = extB - RW'(1);
                    outs_d.oflow = selB == '0;
                end
                A_CMP: begin
                    outs_d.e = selA == selB;
                    outs_d.g = selA > selB;
                    outs_d.l = selA < selB;
                end
                A_MUL_IN: begin
                    isMul      = 1'b1;
                    outs_d.res = (extA + RW'(1)) * (extB + RW'(1));
                end
                A_MUL_S: begin
                    isMul      = 1'b1;
                    outs_d.res = (extA << 1) * extB;
                end
                default: cmdValid = 1'b0;
            endcase
        end else begin
            case (selCmd)
                L_AND:    lres = selA & selB;
                L_NAND:   lres = ~(selA & selB);
                L_OR:     lres = selA | selB;
                L_NOR:    lres = ~(selA | selB);
                L_XOR:    lres = selA ^ selB;
                L_XNOR:   lres = ~(selA ^ selB);
                L_NOT_A:  begin needB = 1'b0; lres = ~selA;      end
                L_NOT_B:  begin needA = 1'b0; lres = ~selB;      end
                L_SHR1_A: begin needB = 1'b0; lres = selA >> 1;  end
                L_SHL1_A: begin needB = 1'b0; lres = selA << 1;  end
                L_SHR1_B: begin needA = 1'b0; lres = selB >> 1;  end
                L_SHL1_B: begin needA = 1'b0; lres = selB << 1;  end
                L_ROL: begin
                    logErr = rotBad;
                    lres   = (selA << rotAmt) | (selA >> (32'(WIDTH) - rotAmt));
                end
                L_ROR: begin
                    logErr = rotBad;
                    lres   = (selA >> rotAmt) | (selA << (32'(WIDTH) - rotAmt));
                end
                default: cmdValid = 1'b0;
            endcase
            outs_d.res = logErr ? '0 : {1'b0, lres};
            outs_d.err = logErr;
        end
        if (!cmdValid) begin
            outs_d = errOut;
        end
    end

    assign covered = (!needA || aluBus.inpValid[0]) && (!needB || aluBus.inpValid[1]);
    assign arrival = waitB_q ? aluBus.inpValid[1] : aluBus.inpValid[0];

    // Control FSM with registered outputs; only clock-enabled edges advance it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            waitB_q <= 1'b0;
            outEn_q <= 1'b0;
            outs_q  <= '0;
        end else if (aluBus.ce) begin
            case (state_q)
                IDLE: begin
                    if (aluBus.inpValid == 2'b00 || !cmdValid) begin
                        outs_q  <= errOut;
                        outEn_q <= 1'b1;
                    end else if (covered) begin
                        if (isMul) begin
                            opa_q   <= aluBus.opa;
                            opb_q   <= aluBus.opb;
                            cmd_q   <= aluBus.cmd;
                            mode_q  <= aluBus.mode;
                            cin_q   <= aluBus.cin;
                            state_q <= MUL_STAGE;
                        end else begin
                            outs_q  <= outs_d;
                            outEn_q <= 1'b1;
                        end
                    end else if (needA && needB) begin
                        if (aluBus.inpValid[0]) opa_q <= aluBus.opa;
                        if (aluBus.inpValid[1]) opb_q <= aluBus.opb;
                        cmd_q   <= aluBus.cmd;
                        mode_q  <= aluBus.mode;
                        cin_q   <= aluBus.cin;
                        waitB_q <= aluBus.inpValid[0];
                        cnt_q   <= '0;
                        state_q <= WAIT_OP;
                    end else begin
                        outs_q  <= errOut;
                        outEn_q <= 1'b1;
                    end
                end
                WAIT_OP: begin
                    opa_q <= selA;
                    opb_q <= selB;
                    if (arrival) begin
                        cnt_q <= '0;
                        if (isMul) begin
                            state_q <= MUL_STAGE;
                        end else begin
                            outs_q  <= outs_d;
                            outEn_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        cnt_q   <= '0;
                        outs_q  <= errOut;
                        outEn_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                MUL_STAGE: begin
                    outs_q  <= outs_d;
                    outEn_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_o   = outEn_q ? outs_q.res   : {RW{1'bz}};
    assign err_o   = outEn_q ? outs_q.err   : 1'bz;
    assign oflow_o = outEn_q ? outs_q.oflow : 1'bz;
    assign cout_o  = outEn_q ? outs_q.cout  : 1'bz;
    assign g_o     = outEn_q ? outs_q.g     : 1'bz;
    assign l_o     = outEn_q ? outs_q.l     : 1'bz;
    assign e_o     = outEn_q ? outs_q.e     : 1'bz;
endmodule
